ps2_host_tx: RTL



---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_line_filter.sv | 61 ++++++
 rtl/ps2_host_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line conditioning:
// FSM state encoding, common keyboard command bytes and 16 MHz timing defaults.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_FIRST,
        BITS,
        ACK,
        WAIT_IDLE,
        FAIL
    } ps2_state_t;

    // Keyboard command / response bytes
    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] ACK_BYTE      = 8'hFA;

    // Timing defaults for a 16 MHz system clock
    localparam int DEF_INHIBIT_CYCLES = 1920;    // 120 us clock inhibit
    localparam int DEF_FIRST_TIMEOUT  = 240000;  // 15 ms to first device edge
    localparam int DEF_FRAME_TIMEOUT  = 32000;   // 2 ms from first edge to ack
    localparam int DEF_FILTER_CYCLES  = 8;       // clock stability filter depth

    localparam int TIMEOUT_W   = 18;
    localparam int MAX_RETRIES = 2;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronizers on clock and data, a stability
// filter on the clock, and a one-cycle strobe on each accepted falling edge.
// Shared with the keyboard receiver path.
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_clk,
    input  logic line_data,
    output logic clk_level,
    output logic data_level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [1:0]    meta_reg;       // {data, clock} first stage
    logic [1:0]    sync_reg;       // {data, clock} second stage
    logic          clk_filt_reg;
    logic          fall_reg;
    logic [CW-1:0] stable_cnt_reg;

    // Two-stage synchronizer; idle PS/2 lines are high, so reset to 1
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 2'b11;
            sync_reg <= 2'b11;
        end else begin
            meta_reg <= {line_data, line_clk};
            sync_reg <= meta_reg;
        end
    end

    // Accept a new clock level only after FILTER_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt_reg   <= 1'b1;
            stable_cnt_reg <= '0;
            fall_reg       <= 1'b0;
        end else begin
            fall_reg <= 1'b0;
            if (sync_reg[0] == clk_filt_reg) begin
                stable_cnt_reg <= '0;
            end else if (stable_cnt_reg == CNT_LAST) begin
                clk_filt_reg   <= sync_reg[0];
                stable_cnt_reg <= '0;
                // flipping away from 1 means the filtered clock just fell
                fall_reg       <= clk_filt_reg;
            end else begin
                stable_cnt_reg <= stable_cnt_reg + CW'(1);
            end
        end
    end

    assign clk_level  = clk_filt_reg;
    assign data_level = sync_reg[1];
    assign fall       = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the clock, issues a request-to-send,
// then shifts start/data/parity/stop out on device falling edges and checks the
// device ack. Line outputs are pull-low enables for open-drain drivers.
// Optional automatic resend (up to two retries) when PS2_HOST_TX_RETRY_EN is defined.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int FIRST_TIMEOUT  = DEF_FIRST_TIMEOUT,
    parameter int FRAME_TIMEOUT  = DEF_FRAME_TIMEOUT,
    parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       tx_active,
    input  logic       clkps2_in,
    input  logic       dataps2_in,
    output logic       clkps2_oe,
    output logic       dataps2_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0]     INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] FIRST_LAST = TIMEOUT_W'(FIRST_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] FRAME_LAST = TIMEOUT_W'(FRAME_TIMEOUT - 1);

    logic clk_level, data_level, fall;

    ps2_line_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .line_clk  (clkps2_in),
        .line_data (dataps2_in),
        .clk_level (clk_level),
        .data_level(data_level),
        .fall      (fall)
    );

    ps2_state_t           state_reg, state_next;
    logic [INH_W-1:0]     inh_cnt_reg, inh_cnt_next;
    logic [TIMEOUT_W-1:0] to_cnt_reg, to_cnt_next, to_cnt_inc;
    logic [3:0]           bit_cnt_reg, bit_cnt_next;
    logic [7:0]           shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 data_oe_reg, data_oe_next;
    logic                 ack_reg, ack_next;
`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0]           retry_reg, retry_next;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            inh_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            ack_reg     <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_reg   <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            inh_cnt_reg <= inh_cnt_next;
            to_cnt_reg  <= to_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            data_oe_reg <= data_oe_next;
            ack_reg     <= ack_next;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_reg   <= retry_next;
`endif
        end
    end

    // Next-state, datapath updates and line/handshake outputs
    always_comb begin
        state_next   = state_reg;
        inh_cnt_next = inh_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        data_oe_next = data_oe_reg;
        ack_next     = ack_reg;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_next   = retry_reg;
`endif
        tx_ready   = 1'b0;
        tx_done    = 1'b0;
        tx_err     = 1'b0;
        tx_active  = 1'b1;
        clkps2_oe  = 1'b0;
        dataps2_oe = 1'b0;
        // timeout counter saturates rather than wrapping
        to_cnt_inc = (&to_cnt_reg) ? to_cnt_reg : to_cnt_reg + TIMEOUT_W'(1);

        case (state_reg)
            IDLE: begin
                tx_ready  = 1'b1;
                tx_active = 1'b0;
                if (tx_valid) begin
                    shift_next   = tx_data;
                    parity_next  = odd_parity(tx_data);
                    inh_cnt_next = '0;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_next   = '0;
`endif
                    state_next   = INHIBIT;
                end
            end
            INHIBIT: begin
                clkps2_oe  = 1'b1;
                // data goes low while clock is still held, so the device sees a clean RTS
                dataps2_oe = (inh_cnt_reg == INH_LAST);
                if (inh_cnt_reg == INH_LAST) begin
                    state_next = REQ;
                end else begin
                    inh_cnt_next = inh_cnt_reg + INH_W'(1);
                end
            end
            REQ: begin
                dataps2_oe   = 1'b1;
                data_oe_next = 1'b1;
                bit_cnt_next = '0;
                // the REQ cycle already counts towards the first-edge wait
                to_cnt_next  = TIMEOUT_W'(1);
                state_next   = WAIT_FIRST;
            end
            WAIT_FIRST: begin
                dataps2_oe  = data_oe_reg;
                to_cnt_next = to_cnt_inc;
                if (fall) begin
                    bit_cnt_next = 4'd1;
                    data_oe_next = ~shift_reg[0];
                    to_cnt_next  = TIMEOUT_W'(1);
                    state_next   = BITS;
                end else if (to_cnt_reg >= FIRST_LAST) begin
                    state_next = FAIL;
                end
            end
            BITS: begin
                dataps2_oe  = data_oe_reg;
                to_cnt_next = to_cnt_inc;
                if (fall) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg < 4'd8) begin
                        data_oe_next = ~shift_reg[bit_cnt_reg[2:0]];
                    end else if (bit_cnt_reg == 4'd8) begin
                        data_oe_next = ~parity_reg;
                    end else if (bit_cnt_reg == 4'd9) begin
                        data_oe_next = 1'b0;
                    end else begin
                        // eleventh fall: device should be holding data low
                        ack_next   = data_level;
                        state_next = ACK;
                    end
                end else if (to_cnt_reg >= FRAME_LAST) begin
                    state_next = FAIL;
                end
            end
            ACK: begin
                to_cnt_next = to_cnt_inc;
                state_next  = ack_reg ? FAIL : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                to_cnt_next = to_cnt_inc;
                if (clk_level && data_level) begin
                    tx_done    = 1'b1;
                    state_next = IDLE;
                end else if (to_cnt_reg >= FRAME_LAST) begin
                    state_next = FAIL;
                end
            end
            FAIL: begin
`ifdef PS2_HOST_TX_RETRY_EN
                if (retry_reg < 2'(MAX_RETRIES)) begin
                    retry_next   = retry_reg + 2'd1;
                    inh_cnt_next = '0;
                    state_next   = INHIBIT;
                end else begin
                    tx_err     = 1'b1;
                    state_next = IDLE;
                end
`else
                tx_err     = 1'b1;
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
